// File: rtl/matrix_result_writeback.sv
// Result writeback: buffers controller results in a FIFO and drains
// them to memory at consecutive addresses from a programmed base.
module matrix_result_writeback #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] baseAddr,
   input  logic [CNT_W-1:0]  elemCount,
   input  logic              resWrite,
   input  logic [DATA_W-1:0] resData,
   output logic              memReq,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memData,
   input  logic              memAck,
   output logic              busy,
   output logic              done,
   output logic              almostFull,
   output logic              overflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]        state;
   logic [DATA_W-1:0] fifo [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [PW:0]       occ;
   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  accepted;
   logic [CNT_W-1:0]  written;
   logic              ovf;

   logic active;
   logic full;
   logic empty;
   logic pop;
   logic push;
   logic drop;
   logic last;
   logic go;

   assign active = (state == S_ACTIVE);
   assign full   = (occ == (PW+1)'(DEPTH));
   assign empty  = (occ == '0);
   assign go     = start && (state == S_IDLE);

   assign memReq = active && !empty;
   assign pop    = memReq && memAck;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign push   = active && resWrite && (!full || pop)
                   && (accepted < count);
   assign drop   = active && resWrite && !push;
   assign last   = pop && ((written + CNT_W'(1)) == count);

   assign memAddr    = base + ADDR_W'(written);
   assign memData    = memReq ? fifo[rd_ptr] : '0;
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);
   assign almostFull = (occ >= (PW+1)'(DEPTH - 1));
   assign overflow   = ovf;

   // Job sequencing: idle, draining, one-cycle completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= (elemCount == '0) ? S_DONE : S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               if (last) begin
                  state <= S_DONE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Job parameters, progress counters and sticky drop flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base     <= '0;
         count    <= '0;
         accepted <= '0;
         written  <= '0;
         ovf      <= 1'b0;
      end else if (go) begin
         base     <= baseAddr;
         count    <= elemCount;
         accepted <= '0;
         written  <= '0;
         ovf      <= 1'b0;
      end else begin
         if (push) begin
            accepted <= accepted + CNT_W'(1);
         end
         if (pop) begin
            written <= written + CNT_W'(1);
         end
         if (drop) begin
            ovf <= 1'b1;
         end
      end
   end

   // FIFO pointers and occupancy; pointers wrap since DEPTH is 2^n.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else if (go) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   occ <= occ + (PW+1)'(1);
            2'b01:   occ <= occ - (PW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo[wr_ptr] <= resData;
      end
   end

endmodule

// File: tb/tb_matrix_result_writeback.sv
// Directed bench for matrix_result_writeback: vector table plus
// hand sequences for backpressure, full push+pop and reset mid-job.
module tb_matrix_result_writeback;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] baseAddr = '0;
   logic [15:0] elemCount = '0;
   logic        resWrite = 1'b0;
   logic [31:0] resData = '0;
   logic        memReq;
   logic [15:0] memAddr;
   logic [31:0] memData;
   logic        memAck = 1'b0;
   logic        busy;
   logic        done;
   logic        almostFull;
   logic        overflow;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   matrix_result_writeback #(
      .DATA_W(32), .ADDR_W(16), .CNT_W(16), .DEPTH(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .baseAddr(baseAddr), .elemCount(elemCount),
      .resWrite(resWrite), .resData(resData),
      .memReq(memReq), .memAddr(memAddr), .memData(memData),
      .memAck(memAck), .busy(busy), .done(done),
      .almostFull(almostFull), .overflow(overflow)
   );

   typedef struct {
      logic        st;
      logic [15:0] base;
      logic [15:0] cnt;
      logic        rw;
      logic [31:0] rd;
      logic        ack;
      logic [52:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [52:0] outs();
      return {memReq, memAddr, memData, busy, done, almostFull, overflow};
   endfunction

   task automatic add(input logic st, input logic [15:0] b,
                      input logic [15:0] c, input logic rw,
                      input logic [31:0] rd, input logic ack,
                      input logic req, input logic [15:0] a,
                      input logic [31:0] d, input logic bz,
                      input logic dn, input logic af, input logic ov);
      vec_t v;
      v.st = st; v.base = b; v.cnt = c; v.rw = rw; v.rd = rd; v.ack = ack;
      v.exp = {req, a, d, bz, dn, af, ov};
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic [15:0] b,
                        input logic [15:0] c, input logic rw,
                        input logic [31:0] rd, input logic ack);
      start = st; baseAddr = b; elemCount = c;
      resWrite = rw; resData = rd; memAck = ack;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // basic job, pushes every 4 cycles
      add(1,'h0100,4,0,0,1, 0,'h0000,0,0,0,0,0);
      add(0,0,0,1,'h11,1,   0,'h0100,0,1,0,0,0);
      add(0,0,0,0,0,1,      1,'h0100,'h11,1,0,0,0);
      add(0,0,0,0,0,1,      0,'h0101,0,1,0,0,0);
      add(0,0,0,0,0,1,      0,'h0101,0,1,0,0,0);
      add(0,0,0,1,'h22,1,   0,'h0101,0,1,0,0,0);
      add(0,0,0,0,0,1,      1,'h0101,'h22,1,0,0,0);
      add(0,0,0,0,0,1,      0,'h0102,0,1,0,0,0);
      add(0,0,0,0,0,1,      0,'h0102,0,1,0,0,0);
      add(0,0,0,1,'h33,1,   0,'h0102,0,1,0,0,0);
      add(0,0,0,0,0,1,      1,'h0102,'h33,1,0,0,0);
      add(0,0,0,0,0,1,      0,'h0103,0,1,0,0,0);
      add(0,0,0,0,0,1,      0,'h0103,0,1,0,0,0);
      add(0,0,0,1,'h44,1,   0,'h0103,0,1,0,0,0);
      add(0,0,0,0,0,1,      1,'h0103,'h44,1,0,0,0);
      add(0,0,0,0,0,1,      0,'h0104,0,1,1,0,0);
      add(0,0,0,0,0,1,      0,'h0104,0,0,0,0,0);
      // zero-length job
      add(1,'h0040,0,0,0,1, 0,'h0104,0,0,0,0,0);
      add(0,0,0,0,0,1,      0,'h0040,0,1,1,0,0);
      add(0,0,0,0,0,1,      0,'h0040,0,0,0,0,0);
      // address wrap, back-to-back pushes
      add(1,'hFFFE,3,0,0,1, 0,'h0040,0,0,0,0,0);
      add(0,0,0,1,'hA1,1,   0,'hFFFE,0,1,0,0,0);
      add(0,0,0,1,'hA2,1,   1,'hFFFE,'hA1,1,0,0,0);
      add(0,0,0,1,'hA3,1,   1,'hFFFF,'hA2,1,0,0,0);
      add(0,0,0,0,0,1,      1,'h0000,'hA3,1,0,0,0);
      add(0,0,0,0,0,1,      0,'h0001,0,1,1,0,0);
      add(0,0,0,0,0,1,      0,'h0001,0,0,0,0,0);

      #3;
      chk("reset_outs", 64'(outs()), 64'd0);
      tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].st, tbl[i].base, tbl[i].cnt,
               tbl[i].rw, tbl[i].rd, tbl[i].ack);
         chk($sformatf("row%0d", i), 64'(outs()), 64'(tbl[i].exp));
         tick();
      end

      // backpressure
      drive(1,'h0200,9,0,0,0);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(0,0,0,1,32'h100 + 32'(i),0);
         tick();
         chk($sformatf("bp_af%0d", i), 64'(almostFull), 64'(i >= 6));
      end
      chk("bp_ov0", 64'(overflow), 64'd0);
      chk("bp_stall", 64'({memReq, memAddr, memData}),
          64'({1'b1, 16'h0200, 32'h100}));
      drive(0,0,0,1,'h1FF,0);
      tick();
      chk("bp_ov1", 64'(overflow), 64'd1);
      drive(0,0,0,0,0,1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("bp_wr%0d", i), 64'({memReq, memAddr, memData}),
             64'({1'b1, 16'h0200 + 16'(i), 32'h100 + 32'(i)}));
         tick();
      end
      chk("bp_nodone", 64'({memReq, busy, done}), 64'b010);
      tick();
      chk("bp_nodone2", 64'({busy, done}), 64'b10);
      drive(0,0,0,1,'h1AA,1);
      tick();
      drive(0,0,0,0,0,1);
      chk("bp_last", 64'({memReq, memAddr, memData}),
          64'({1'b1, 16'h0208, 32'h1AA}));
      tick();
      chk("bp_done", 64'({busy, done, overflow}), 64'b111);
      tick();
      chk("bp_idle", 64'({busy, done}), 64'b00);

      // full FIFO with simultaneous push and pop
      drive(1,'h0300,12,0,0,0);
      tick();
      chk("fp_ovclr", 64'(overflow), 64'd0);
      for (int i = 0; i < 8; i++) begin
         drive(0,0,0,1,32'h500 + 32'(i),0);
         tick();
      end
      chk("fp_af", 64'({almostFull, overflow}), 64'b10);
      drive(0,0,0,1,'h508,1);
      tick();
      chk("fp_pp", 64'({overflow, almostFull, memAddr, memData}),
          64'({1'b0, 1'b1, 16'h0301, 32'h501}));
      drive(0,0,0,1,'h5EE,0);
      tick();
      chk("fp_stillfull", 64'(overflow), 64'd1);
      drive(0,0,0,0,0,1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("fp_wr%0d", i), 64'({memReq, memAddr, memData}),
             64'({1'b1, 16'h0301 + 16'(i), 32'h501 + 32'(i)}));
         tick();
      end
      chk("fp_empty", 64'({memReq, busy}), 64'b01);

      // reset in the middle of a job
      drive(0,0,0,1,'h5AB,0);
      tick();
      drive(0,0,0,0,0,0);
      chk("rs_req", 64'(memReq), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rs_async", 64'({memReq, busy, overflow, almostFull}), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      drive(1,'h0020,1,0,0,1);
      tick();
      drive(0,0,0,1,'h77,1);
      tick();
      drive(0,0,0,0,0,1);
      chk("rs_wr", 64'({memReq, memAddr, memData}),
          64'({1'b1, 16'h0020, 32'h77}));
      tick();
      chk("rs_done", 64'({memReq, busy, done}), 64'b011);
      tick();
      chk("rs_idle", 64'({memReq, busy, done}), 64'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
